// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit holding the HI/LO registers.
// Arithmetic ops run for a fixed number of cycles (busy high) before HI/LO are
// written; mthi/mtlo write in a single cycle while idle.
// Optional build macro MDU_MADD_EN adds signed madd (110) / msub (111).
//
// Launch handshake: an op is accepted on a rising edge where start=1, the
// unit is idle (busy=0) and the op code is an arithmetic op; there is no
// back-pressure beyond busy, so anything presented while busy=1 is dropped.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mult_div_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  out_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mduState_t;

    mduState_t        state;
    mduState_t        stateNext;
    logic [CNT_W-1:0] counter;
    logic [2:0]       opReg;
    logic [31:0]      aReg;
    logic [31:0]      bReg;

    logic             isLaunchOp;
    logic             launch;
    logic             moveHi;
    logic             moveLo;
    logic             finish;

    logic [63:0]      sProd;
    logic [63:0]      uProd;
    logic [31:0]      absA;
    logic [31:0]      absB;
    logic [31:0]      magQuot;
    logic [31:0]      magRem;
    logic [31:0]      sQuot;
    logic [31:0]      sRem;
    logic             resWrite;
    logic [63:0]      resHiLo;

    // Decode which requests are accepted this cycle.
    always_comb begin
`ifdef MDU_MADD_EN
        isLaunchOp = ~mult_div_op[2] | (mult_div_op[2] & mult_div_op[1]);
`else
        isLaunchOp = ~mult_div_op[2];
`endif
        launch = (state == IDLE) && start && isLaunchOp;
        moveHi = (state == IDLE) && !start && (mult_div_op == 3'b100);
        moveLo = (state == IDLE) && !start && (mult_div_op == 3'b101);
        finish = (state == RUN) && (counter == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (launch) stateNext = RUN;
            RUN:     if (finish) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs and read-out mux.
    always_comb begin
        busy = (state == RUN);
        case (out_sel)
            2'b01:   mdu_out = HI;
            2'b10:   mdu_out = LO;
            default: mdu_out = 32'h0;
        endcase
    end

    // Result arithmetic on the captured operands. Signed divide works on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    always_comb begin
        sProd   = {{32{aReg[31]}}, aReg} * {{32{bReg[31]}}, bReg};
        uProd   = {32'h0, aReg} * {32'h0, bReg};
        absA    = aReg[31] ? (~aReg + 32'h1) : aReg;
        absB    = bReg[31] ? (~bReg + 32'h1) : bReg;
        magQuot = (absB == 32'h0) ? 32'h0 : (absA / absB);
        magRem  = (absB == 32'h0) ? 32'h0 : (absA % absB);
        sQuot   = (aReg[31] ^ bReg[31]) ? (~magQuot + 32'h1) : magQuot;
        sRem    = aReg[31] ? (~magRem + 32'h1) : magRem;

        resWrite = 1'b1;
        resHiLo  = {HI, LO};
        case (opReg)
            3'b000: resHiLo = sProd;
            3'b001: resHiLo = uProd;
            3'b010: begin
                if (bReg == 32'h0) resWrite = 1'b0;
                else               resHiLo  = {sRem, sQuot};
            end
            3'b011: begin
                if (bReg == 32'h0) resWrite = 1'b0;
                else               resHiLo  = {aReg % bReg, aReg / bReg};
            end
`ifdef MDU_MADD_EN
            3'b110: resHiLo = {HI, LO} + sProd;
            3'b111: resHiLo = {HI, LO} - sProd;
`endif
            default: resWrite = 1'b0;
        endcase
    end

    // Operand capture, latency counter and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            opReg   <= 3'b000;
            aReg    <= 32'h0;
            bReg    <= 32'h0;
            HI      <= 32'h0;
            LO      <= 32'h0;
        end else if (launch) begin
            opReg   <= mult_div_op;
            aReg    <= A;
            bReg    <= B;
            counter <= (mult_div_op[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (state == RUN) begin
            counter <= counter - CNT_W'(1);
            if (finish && resWrite) begin
                HI <= resHiLo[63:32];
                LO <= resHiLo[31:0];
            end
        end else if (moveHi) begin
            HI <= A;
        end else if (moveLo) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected {HI,LO} results are queued at
// launch and compared when busy falls; moves, read-out, divide by zero and
// reset abort are checked inline.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  outSel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mduOut;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] expQ[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mult_div_op (op),
        .A           (a),
        .B           (b),
        .out_sel     (outSel),
        .busy        (busy),
        .HI          (hi),
        .LO          (lo),
        .mdu_out     (mduOut)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one launch for one cycle, then scramble the operands.
    task automatic launchOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 3'b000;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait for busy to drop, check the busy length and the queued result.
    task automatic waitDone(input string tag, input int expCycles);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(expCycles));
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            check({tag, " hilo"}, {hi, lo}, expQ.pop_front());
        end
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        a      = 32'h0;
        b      = 32'h0;
        outSel = 2'b00;
        tick();
        tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        tick();

        // Signed and unsigned multiply.
        expQ.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
        launchOp(3'b000, 32'hFFFFFFFF, 32'h2);
        waitDone("mult", 5);

        expQ.push_back({32'h00000001, 32'hFFFFFFFE});
        launchOp(3'b001, 32'hFFFFFFFF, 32'h2);
        waitDone("multu", 5);

        // Divides: negative dividend, negative divisor, unsigned, overflow.
        expQ.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        launchOp(3'b010, 32'hFFFFFFF9, 32'h2);
        waitDone("div_neg_dividend", 10);

        expQ.push_back({32'h00000001, 32'hFFFFFFFD});
        launchOp(3'b010, 32'h7, 32'hFFFFFFFE);
        waitDone("div_neg_divisor", 10);

        expQ.push_back({32'h1, 32'h3});
        launchOp(3'b011, 32'h7, 32'h2);
        waitDone("divu", 10);

        expQ.push_back({32'h0, 32'h80000000});
        launchOp(3'b010, 32'h80000000, 32'hFFFFFFFF);
        waitDone("div_overflow", 10);

        // Random unsigned operands.
        rx = $urandom;
        ry = 32'($urandom_range(1, 65535));
        expQ.push_back({32'h0, rx} * {32'h0, ry});
        launchOp(3'b001, rx, ry);
        waitDone("multu_rand", 5);

        rx = $urandom;
        ry = 32'($urandom_range(1, 1000));
        expQ.push_back({rx % ry, rx / ry});
        launchOp(3'b011, rx, ry);
        waitDone("divu_rand", 10);

        // Moves and read-out.
        op = 3'b100; a = 32'h12345678;
        tick();
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi hi", 64'(hi), 64'h12345678);
        op = 3'b101; a = 32'h9ABCDEF0;
        tick();
        op = 3'b000;
        check("mtlo lo", 64'(lo), 64'h9ABCDEF0);
        outSel = 2'b01; #1;
        check("out_sel hi", 64'(mduOut), 64'h12345678);
        outSel = 2'b10; #1;
        check("out_sel lo", 64'(mduOut), 64'h9ABCDEF0);
        outSel = 2'b00; #1;
        check("out_sel 00", 64'(mduOut), 64'h0);
        outSel = 2'b11; #1;
        check("out_sel 11", 64'(mduOut), 64'h0);

        // start with a move code: no-op, move ignored.
        op = 3'b101; a = 32'hDEADBEEF; start = 1'b1;
        tick();
        start = 1'b0; op = 3'b000;
        check("start_mtlo busy", 64'(busy), 64'd0);
        check("start_mtlo hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

`ifndef MDU_MADD_EN
        op = 3'b110; start = 1'b1;
        tick();
        start = 1'b0; op = 3'b000;
        check("op110 noop busy", 64'(busy), 64'd0);
`endif

        // Divide by zero with an mthi attempted mid-busy.
        op = 3'b100; a = 32'h11;
        tick();
        op = 3'b101; a = 32'h22;
        tick();
        op = 3'b000;
        expQ.push_back({32'h11, 32'h22});
        launchOp(3'b010, 32'h5, 32'h0);
        op = 3'b100; a = 32'h99;
        outSel = 2'b01; #1;
        check("run readout old hi", 64'(mduOut), 64'h11);
        tick();
        op = 3'b000;
        waitDone("div_by_zero", 9);

        // Reset on the third busy cycle of a mult.
        launchOp(3'b000, 32'h3, 32'h4);
        tick();
        tick();
        check("pre_reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, 64'h0);
        repeat (10) tick();
        check("no late write busy", 64'(busy), 64'd0);
        check("no late write hilo", {hi, lo}, 64'h0);
        check("queue drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit; consumes the start / mult_div_op / out_sel control that the decode stage generates for mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Holds the architectural HI/LO registers.
- Models multi-cycle latency with a busy flag, which the hazard unit uses to stall decode.
- Exposes HI or LO as a read-out word for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle launch strobe for mult/multu/div/divu.
- mult_div_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others no-op.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- out_sel  input  2  01 selects HI, 10 selects LO, other values give 0.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- mdu_out  output  32  combinational read-out selected by out_sel.

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, state IDLE. Reset applies in any state and aborts an in-flight operation; that result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; an internal counter counts down.
- IDLE to RUN: on an edge with start=1 and mult_div_op in {000..011}.
  - A and B are captured into internal operand registers, and the op is latched.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements each cycle.
  - At the edge where counter==1, HI/LO are written with the result, busy falls and the state returns to IDLE.
  - busy is therefore high for exactly N cycles; the new HI/LO are visible in the cycle busy first reads 0.
- Arithmetic, on the captured operands:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero (B==0 for div/divu): full latency is still spent; HI and LO stay unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: single cycle, no busy. Accepted only in IDLE when start=0; HI (or LO) is written from A at that edge.
- While busy=1: start, mthi and mtlo are all ignored. The decode stall on busy|start guarantees legal code never issues them then.
- start=1 with a non-arithmetic op code: treated as a no-op; state stays IDLE.
- start and mthi/mtlo in the same cycle: start wins and the move is ignored.
- mdu_out: purely combinational from current HI/LO. During RUN it shows the old values, because decode stalls mfhi/mflo until busy=0.
- Operand changes on A/B after the launch edge have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, op 110 = madd and 111 = msub (both signed), launched with start and taking MULT_CYCLES.
  - Result written at completion is {HI,LO} = {HI,LO} ± signed product, modulo 2^64.
  - {HI,LO} is read at completion, not at launch.
- When not defined, 110 and 111 are no-ops, identical to other unused codes.

Test Plan:
- Signed multiply: mult with A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned multiply: multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Signed divide: div with A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with divu A=7, B=2 -> LO=3, HI=1.
- Moves and read-out: mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> HI/LO updated next edge with busy=0; out_sel=01 gives mdu_out=0x12345678, out_sel=10 gives 0x9ABCDEF0.
- Divide by zero and mid-busy move: div with B=0 after HI/LO=0x11/0x22 -> 10 busy cycles, then HI/LO still 0x11/0x22. mthi issued during that busy window is ignored.
- Reset mid-operation: assert reset on the 3rd busy cycle of a mult -> next cycle busy=0, HI=LO=0, and no late write occurs afterward.
